spn_iter_core: RTL and testbench
================================

SPN_ITER_CORE -- requirements
Module: spn_iter_core

Interface
REQ-001 Parameter DW, default 16, data width; multiple of 4, range 8..64.
REQ-002 Parameter KW, default 32, key width; multiple of 4, KW >= DW.
REQ-003 Parameter ROUNDS, default 4, round count; range 1..15.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 opcode  in  2  00 nop, 01 encrypt, 10 decrypt, 11 undefined.
REQ-009 data_in  in  DW  plaintext or ciphertext.
REQ-010 symmetric_secret_key  in  KW  secret key.
REQ-011 out_valid  out  1  result present.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 data_out  out  DW  result.
REQ-014 status  out  2  01 encrypt ok, 10 decrypt ok, 11 undefined op; 00 when out_valid=0.
REQ-015 err_cnt  out  8  undefined-opcode counter (see Configuration).

Function
REQ-016 A request transfers on any cycle where in_valid=1 and in_ready=1; opcode, data_in and key are captured in that cycle, and later input changes are ignored.
REQ-017 FSM states: IDLE, RUN, DONE; in_ready=1 only in IDLE.
REQ-018 IDLE: transfer with opcode 00 is consumed with no output and FSM stays IDLE.
REQ-019 IDLE: transfer with opcode 11 goes to DONE with data_out=0 and status=11.
REQ-020 IDLE: transfer with opcode 01 or 10 goes to RUN and loads round counter with 1.
REQ-021 S-box S (4-bit, nibble-wise, hex for inputs 0..F) = C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2; S^-1 is its exact inverse.
REQ-022 Permutation P: bit i moves to (i*4) mod (DW-1) for i < DW-1, and bit DW-1 stays fixed; P^-1 is its inverse.
REQ-023 Round key rk_r = upper DW bits of (captured key rotated left by 4*r mod KW), r = 0..ROUNDS.
REQ-024 Encrypt: at transfer, state = data_in XOR rk_0; in RUN, one round per cycle, state = P(S(state)) XOR rk_r for r = 1..ROUNDS.
REQ-025 Decrypt: at transfer, state = data_in XOR rk_ROUNDS; in RUN, state = S^-1(P^-1(state)) XOR rk_(ROUNDS-r) for r = 1..ROUNDS.
REQ-026 Decrypt(Encrypt(x,k),k) SHALL equal x for all x, k and every legal parameter set.
REQ-027 After round ROUNDS, FSM goes to DONE; out_valid rises exactly ROUNDS+1 cycles after the transfer edge.
REQ-028 Undefined-opcode results assert out_valid 1 cycle after the transfer edge.
REQ-029 DONE: out_valid=1 and data_out/status are held stable until out_ready=1, then FSM goes to IDLE on that edge.
REQ-030 out_ready is ignored whenever out_valid=0.
REQ-031 After a result is consumed, in_ready=1 on the next cycle; there is no back-to-back overlap (throughput 1 result per ROUNDS+2 cycles minimum).
REQ-032 The round counter is 4 bits and never wraps; it is reloaded on each transfer.

Reset
REQ-033 rst=0 immediately forces IDLE, in_ready=1 (after reset release), out_valid=0, data_out=0, status=00, err_cnt=0, and clears state and counter.
REQ-034 Reset asserted during RUN or DONE discards the in-flight operation; no result is produced after release.
REQ-035 During rst=0, in_ready SHALL be 0.

Configuration
REQ-036 Macro SPN_ERR_COUNT_EN defined: err_cnt increments by 1 on each accepted opcode-11 transfer and saturates at 255.
REQ-037 Macro SPN_ERR_COUNT_EN undefined: port err_cnt is present, tied to 0, and no counter logic is built.

Verification
REQ-038 Enc then dec: DW=16, KW=32, ROUNDS=4, key 0x0123_4567, data 0xBEEF encrypted, then the result decrypted with the same key -> 0xBEEF, status 01 then 10; each out_valid at +5 cycles; encrypt result also matches the C reference model.
REQ-039 Opcode 11, data 0x1234 -> out_valid one cycle later, data_out 0x0000, status 11; err_cnt=1 with the macro, 0 without.
REQ-040 Backpressure: hold out_ready=0 for 10 cycles -> data_out/status stable, in_ready=0, and a new in_valid is not accepted; out_ready=1 -> in_ready=1 on the next cycle.
REQ-041 Opcode 00 with in_valid=1 -> no out_valid over 20 cycles, and in_ready stays 1.
REQ-042 rst pulsed low at round 2 of an encrypt -> outputs cleared asynchronously, and no out_valid after release.
REQ-043 With the macro, 300 opcode-11 requests -> err_cnt=255.

Source files
------------

// File: rtl/spn_iter_core.sv
// Iterative 4-bit S-box / bit-permutation block cipher core, one round per cycle.
// Optional undefined-opcode counter is built when SPN_ERR_COUNT_EN is defined.
module spn_iter_core #(
  parameter int unsigned DW     = 16,
  parameter int unsigned KW     = 32,
  parameter int unsigned ROUNDS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    opcode,
  input  logic [DW-1:0] data_in,
  input  logic [KW-1:0] symmetric_secret_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic [1:0]    status,
  output logic [7:0]    err_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] OpNop = 2'b00;
  localparam logic [1:0] OpEnc = 2'b01;
  localparam logic [1:0] OpDec = 2'b10;
  localparam logic [1:0] OpUnd = 2'b11;

  localparam logic [3:0]  LastRound  = 4'(ROUNDS);
  localparam int unsigned LastKeyRot = (4 * ROUNDS) % KW;
  localparam int unsigned DecKeyRot  = (4 * (ROUNDS - 1)) % KW;

  // Nibble lookup tables, entry for input n sits at bits [4n+3:4n].
  localparam logic [63:0] Sbox    = 64'h2174_8FE3_DA09_B65C;
  localparam logic [63:0] SboxInv = 64'hA970_364B_D21C_8FE5;

  function automatic logic [DW-1:0] sub_fwd(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    for (int unsigned n = 0; n < DW / 4; n++) begin
      y[4*n +: 4] = Sbox[{x[4*n +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] sub_inv(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    for (int unsigned n = 0; n < DW / 4; n++) begin
      y[4*n +: 4] = SboxInv[{x[4*n +: 4], 2'b00} +: 4];
    end
    return y;
  endfunction

  // gcd(4, DW-1) = 1 for DW a multiple of 4, so this is a bijection.
  function automatic logic [DW-1:0] perm_fwd(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y[DW-1] = x[DW-1];
    for (int unsigned i = 0; i < DW - 1; i++) begin
      y[(i * 4) % (DW - 1)] = x[i];
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] perm_inv(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y[DW-1] = x[DW-1];
    for (int unsigned i = 0; i < DW - 1; i++) begin
      y[i] = x[(i * 4) % (DW - 1)];
    end
    return y;
  endfunction

  function automatic logic [KW-1:0] rotl(input logic [KW-1:0] x, input int unsigned amt);
    logic [KW-1:0] y;
    for (int unsigned i = 0; i < KW; i++) begin
      y[(i + amt) % KW] = x[i];
    end
    return y;
  endfunction

  logic [1:0]    st_q, st_d;
  logic [1:0]    op_q, op_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] blk_q, blk_d;
  logic [KW-1:0] rkey_q, rkey_d;
  logic [KW-1:0] key_last, key_pen, key_first;
  logic          in_xfer;

  assign key_first = rotl(symmetric_secret_key, 4);
  assign key_last  = rotl(symmetric_secret_key, LastKeyRot);
  assign key_pen   = rotl(symmetric_secret_key, DecKeyRot);

  assign in_ready  = (st_q == StIdle) && rst;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (st_q == StDone);
  assign data_out  = out_valid ? blk_q : '0;
  assign status    = out_valid ? op_q : 2'b00;

  // rkey_q always holds the key schedule word whose top DW bits are the next round key.
  always_comb begin
    st_d   = st_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    blk_d  = blk_q;
    rkey_d = rkey_q;
    unique case (st_q)
      StIdle: begin
        if (in_xfer) begin
          op_d  = opcode;
          cnt_d = 4'd1;
          unique case (opcode)
            OpEnc: begin
              blk_d  = data_in ^ symmetric_secret_key[KW-1 -: DW];
              rkey_d = key_first;
              st_d   = StRun;
            end
            OpDec: begin
              blk_d  = data_in ^ key_last[KW-1 -: DW];
              rkey_d = key_pen;
              st_d   = StRun;
            end
            OpUnd: begin
              blk_d = '0;
              st_d  = StDone;
            end
            OpNop: ;
          endcase
        end
      end
      StRun: begin
        if (op_q == OpEnc) begin
          blk_d  = perm_fwd(sub_fwd(blk_q)) ^ rkey_q[KW-1 -: DW];
          rkey_d = rotl(rkey_q, 4);
        end else begin
          blk_d  = sub_inv(perm_inv(blk_q)) ^ rkey_q[KW-1 -: DW];
          rkey_d = rotl(rkey_q, KW - 4);
        end
        if (cnt_q == LastRound) begin
          st_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= StIdle;
      op_q   <= OpNop;
      cnt_q  <= '0;
      blk_q  <= '0;
      rkey_q <= '0;
    end else begin
      st_q   <= st_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      rkey_q <= rkey_d;
    end
  end

`ifdef SPN_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else if (in_xfer && (opcode == OpUnd) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spn_iter_core.sv
// Directed vector bench for spn_iter_core (DW=16, KW=32, ROUNDS=4).
// Expected err_cnt follows SPN_ERR_COUNT_EN as seen by the bench build.
module tb_spn_iter_core;

`ifdef SPN_ERR_COUNT_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  opcode = 2'b00;
  logic [15:0] data_in = 16'h0000;
  logic [31:0] sk = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] data_out;
  logic [1:0]  status;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  spn_iter_core dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .opcode               (opcode),
    .data_in              (data_in),
    .symmetric_secret_key (sk),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .data_out             (data_out),
    .status               (status),
    .err_cnt              (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] din;
    logic [31:0] key;
    logic [15:0] exp_data;
    logic [1:0]  exp_status;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic bump_err();
    if (ErrEn && exp_err < 255) exp_err++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Issues one request and returns at the first negedge where out_valid is seen (or a timeout).
  task automatic do_req(input logic [1:0] op, input logic [15:0] d, input logic [31:0] k,
                        output logic [15:0] rd, output logic [1:0] rs, output int lat,
                        output logic rdy1);
    @(negedge clk);
    wait_ready();
    opcode   = op;
    data_in  = d;
    sk       = k;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = 2'b11;
    data_in  = ~d;
    sk       = ~k;
    rdy1     = in_ready;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = data_out;
    rs = status;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_after_consume", 32'(in_ready), 32'd1);
    check("valid_after_consume", 32'(out_valid), 32'd0);
  endtask

  logic [15:0] rd, cx, x;
  logic [31:0] k;
  logic [1:0]  rs;
  int          lat;
  logic        rdy1;

  initial begin
    vecs[0] = '{2'b01, 16'hBEEF, 32'h0123_4567, 16'h8455, 2'b01, 5};
    vecs[1] = '{2'b10, 16'h8455, 32'h0123_4567, 16'hBEEF, 2'b10, 5};
    vecs[2] = '{2'b01, 16'h0000, 32'h0000_0000, 16'h4BCC, 2'b01, 5};
    vecs[3] = '{2'b10, 16'h4BCC, 32'h0000_0000, 16'h0000, 2'b10, 5};
    vecs[4] = '{2'b11, 16'h1234, 32'hDEAD_BEEF, 16'h0000, 2'b11, 1};

    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      do_req(vecs[i].op, vecs[i].din, vecs[i].key, rd, rs, lat, rdy1);
      if (vecs[i].op == 2'b11) bump_err();
      check($sformatf("vec%0d_data", i), 32'(rd), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_status", i), 32'(rs), 32'(vecs[i].exp_status));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_busy", i), 32'(rdy1), 32'd0);
      check($sformatf("vec%0d_err_cnt", i), 32'(err_cnt), 32'(exp_err));
      consume();
    end

    // Backpressure: result held, new requests refused
    do_req(2'b01, 16'h0000, 32'h0, rd, rs, lat, rdy1);
    check("bp_first_data", 32'(rd), 32'h4BCC);
    in_valid = 1'b1;
    opcode   = 2'b01;
    data_in  = 16'h5555;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(data_out), 32'h4BCC);
      check("bp_status", 32'(status), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("bp_no_phantom", 32'(out_valid), 32'd0);
    end

    // Opcode 00 is swallowed
    in_valid = 1'b1;
    opcode   = 2'b00;
    data_in  = 16'hA5A5;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("nop_valid", 32'(out_valid), 32'd0);
      check("nop_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;

    // Random round trips
    for (int t = 0; t < 4; t++) begin
      x = 16'($urandom);
      k = $urandom;
      do_req(2'b01, x, k, cx, rs, lat, rdy1);
      check("rt_enc_status", 32'(rs), 32'd1);
      check("rt_enc_latency", 32'(lat), 32'd5);
      consume();
      do_req(2'b10, cx, k, rd, rs, lat, rdy1);
      check("rt_dec_data", 32'(rd), 32'(x));
      check("rt_dec_status", 32'(rs), 32'd2);
      check("rt_dec_latency", 32'(lat), 32'd5);
      consume();
    end

    // Reset during round 2 of an encrypt
    @(negedge clk);
    wait_ready();
    opcode   = 2'b01;
    data_in  = 16'hBEEF;
    sk       = 32'h0123_4567;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_status", 32'(status), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    exp_err = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("rel_no_valid", 32'(out_valid), 32'd0);
    end

    // Undefined-opcode counter saturation
    for (int n = 0; n < 300; n++) begin
      do_req(2'b11, 16'(n), 32'h0, rd, rs, lat, rdy1);
      bump_err();
      check("sat_err_cnt", 32'(err_cnt), 32'(exp_err));
      consume();
    end
    check("final_err_cnt", 32'(err_cnt), ErrEn ? 32'd255 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
    $fatal(1);
  end

endmodule
